sb_axi_mem_responder: RTL and testbench

- AXI4 subordinate memory model. It is the responder end of the 512-bit AXI manager port that the FPGA queue block drives toward host memory.
- It serves INCR bursts from an internal byte-strobed RAM.
- It lets the RX/TX queue logic and its crossbar run in simulation and on-chip loopback without a host.
- Read and write paths are independent FSMs; each handles one outstanding burst.

---
 rtl/sb_axi_mem_responder.sv | 179 +++++++++++++++++
 tb/tb_sb_axi_mem_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_axi_mem_responder.sv
// AXI4 subordinate memory model: INCR bursts served from a byte-strobed RAM.
// Read and write channels run as independent single-outstanding-burst FSMs.
module sb_axi_mem_responder #(
  parameter int          ID_WIDTH  = 16,
  parameter int          MEM_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic [ID_WIDTH-1:0] s_axi_awid,
  input  logic [63:0]         s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [511:0]        s_axi_wdata,
  input  logic [63:0]         s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_WIDTH-1:0] s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_WIDTH-1:0] s_axi_arid,
  input  logic [63:0]         s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_WIDTH-1:0] s_axi_rid,
  output logic [511:0]        s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);
  localparam int          AW    = $clog2(MEM_WORDS);
  localparam logic [63:0] DEPTH = 64'(MEM_WORDS);

  logic [511:0] mem [MEM_WORDS];

  function automatic logic [63:0] to_idx(input logic [63:0] a);
    return (a - BASE_ADDR) >> 6;
  endfunction

  // ---------------- write channel ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  w_state_t            w_state;
  logic [63:0]         w_idx;
  logic                w_below, w_err;
  logic [7:0]          w_len;
  logic [8:0]          w_cnt;
  logic                w_inr, w_err_nx, w_we;
  logic [8:0]          w_n, w_len1;

  assign w_inr  = !w_below && (w_idx < DEPTH);
  assign w_n    = w_cnt + 9'd1;
  assign w_len1 = {1'b0, w_len} + 9'd1;
  // Wrong beat count is only final on wlast; overrun without wlast flags early.
  assign w_err_nx = w_err | !w_inr | (s_axi_wlast ? (w_n != w_len1) : (w_n > w_len1));
  assign w_we     = (w_state == W_DATA) && s_axi_wvalid && w_inr && !w_err;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= 2'b00;
      w_idx         <= '0;
      w_below       <= 1'b0;
      w_err         <= 1'b0;
      w_len         <= '0;
      w_cnt         <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (s_axi_awvalid) begin
          s_axi_bid     <= s_axi_awid;
          w_idx         <= to_idx(s_axi_awaddr);
          w_below       <= s_axi_awaddr < BASE_ADDR;
          w_err         <= s_axi_awsize != 3'd6;
          w_len         <= s_axi_awlen;
          w_cnt         <= '0;
          s_axi_awready <= 1'b0;
          s_axi_wready  <= 1'b1;
          w_state       <= W_DATA;
        end
        W_DATA: if (s_axi_wvalid) begin
          if (s_axi_wlast) begin
            s_axi_wready <= 1'b0;
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= w_err_nx ? 2'b10 : 2'b00;
            w_state      <= W_RESP;
          end else begin
            w_idx <= w_idx + 64'd1;
            w_err <= w_err_nx;
            if (w_cnt != '1) w_cnt <= w_n;
          end
        end
        W_RESP: if (s_axi_bready) begin
          s_axi_bvalid  <= 1'b0;
          s_axi_awready <= 1'b1;
          w_state       <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we)
      for (int b = 0; b < 64; b++)
        if (s_axi_wstrb[b]) mem[w_idx[AW-1:0]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
  end

  // ---------------- read channel ----------------
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  r_state_t    r_state;
  logic [7:0]  r_len, r_beat;
  logic [63:0] r_idx, ld_idx;
  logic        r_below, r_err, ld_below, ld_err, ld_ok;

  // Same load path for the first beat (from AR) and each following beat.
  assign ld_idx   = (r_state == R_IDLE) ? to_idx(s_axi_araddr) : r_idx + 64'd1;
  assign ld_below = (r_state == R_IDLE) ? (s_axi_araddr < BASE_ADDR) : r_below;
  assign ld_err   = (r_state == R_IDLE) ? (s_axi_arsize != 3'd6) : r_err;
  assign ld_ok    = !ld_below && (ld_idx < DEPTH) && !ld_err;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rresp   <= 2'b00;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      r_len         <= '0;
      r_beat        <= '0;
      r_idx         <= '0;
      r_below       <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (s_axi_arvalid) begin
          s_axi_rid     <= s_axi_arid;
          r_len         <= s_axi_arlen;
          r_beat        <= '0;
          r_idx         <= ld_idx;
          r_below       <= ld_below;
          r_err         <= ld_err;
          s_axi_rdata   <= ld_ok ? mem[ld_idx[AW-1:0]] : '0;
          s_axi_rresp   <= ld_ok ? 2'b00 : 2'b10;
          s_axi_rlast   <= s_axi_arlen == 8'd0;
          s_axi_rvalid  <= 1'b1;
          s_axi_arready <= 1'b0;
          r_state       <= R_DATA;
        end
        R_DATA: if (s_axi_rready) begin
          if (s_axi_rlast) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_arready <= 1'b1;
            r_state       <= R_IDLE;
          end else begin
            r_idx       <= ld_idx;
            r_beat      <= r_beat + 8'd1;
            s_axi_rdata <= ld_ok ? mem[ld_idx[AW-1:0]] : '0;
            s_axi_rresp <= ld_ok ? 2'b00 : 2'b10;
            s_axi_rlast <= (r_beat + 8'd1) == r_len;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sb_axi_mem_responder.sv
// Directed + randomized bench for sb_axi_mem_responder against a word-array model.
module tb_sb_axi_mem_responder;
  localparam int          IDW   = 16;
  localparam int          WORDS = 1024;
  localparam logic [63:0] BASE  = 64'h0;

  logic           clk, nreset;
  logic [IDW-1:0] awid, bid, arid, rid;
  logic [63:0]    awaddr, araddr, wstrb;
  logic [7:0]     awlen, arlen;
  logic [2:0]     awsize, arsize;
  logic           awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic           arvalid, arready, rlast, rvalid, rready;
  logic [511:0]   wdata, rdata;
  logic [1:0]     bresp, rresp;

  sb_axi_mem_responder #(.ID_WIDTH(IDW), .MEM_WORDS(WORDS), .BASE_ADDR(BASE)) dut (
    .clk(clk), .nreset(nreset),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [511:0] model [WORDS];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic bit in_range(input logic [63:0] addr, input int beat);
    logic [63:0] idx;
    idx = ((addr - BASE) >> 6) + 64'(beat);
    return (addr >= BASE) && (idx < 64'(WORDS));
  endfunction

  function automatic int word_of(input logic [63:0] addr, input int beat);
    return int'(((addr - BASE) >> 6) + 64'(beat));
  endfunction

  task automatic model_write(input logic [63:0] addr, input int beat, input logic [511:0] d,
                             input logic [63:0] st);
    for (int k = 0; k < 64; k++)
      if (st[k]) model[word_of(addr, beat)][k*8 +: 8] = d[k*8 +: 8];
  endtask

  // Full write burst: nbeats sent with wlast on the final one; beat part_beat uses strb_part.
  task automatic do_write(input logic [IDW-1:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input int nbeats, input logic [63:0] strb_part,
                          input int part_beat, input int bdelay);
    bit err;
    logic [511:0] d;
    logic [63:0] st;
    logic [1:0] exp_resp;
    err = (size != 3'd6);
    awid = id; awaddr = addr; awlen = len; awsize = size; awvalid = 1'b1;
    @(negedge clk);
    check("aw_ready", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      d = rnd512();
      st = (b == part_beat) ? strb_part : '1;
      wdata = d; wstrb = st; wlast = (b == nbeats - 1); wvalid = 1'b1;
      @(negedge clk);
      check("w_ready", wready, 1);
      @(posedge clk); #1;
      if (!in_range(addr, b)) err = 1'b1;
      else if (!err) model_write(addr, b, d, st);
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (nbeats != int'(len) + 1) err = 1'b1;
    exp_resp = err ? 2'b10 : 2'b00;
    bready = 1'b0;
    for (int k = 0; k <= bdelay; k++) begin
      if (k == bdelay) bready = 1'b1;
      @(negedge clk);
      check("b_valid", bvalid, 1);
      check("b_id", bid, id);
      check("b_resp", bresp, exp_resp);
      @(posedge clk); #1;
    end
    bready = 1'b0;
    @(negedge clk);
    check("b_drop", bvalid, 0);
    check("aw_reopen", awready, 1);
    @(posedge clk); #1;
  endtask

  // Read burst; with bp set, rready follows the repeating pattern 1,0,0,1.
  task automatic do_read(input logic [IDW-1:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input bit bp);
    logic [511:0] exp_d [$];
    logic [1:0]   exp_r [$];
    bit ok;
    int b, cyc;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i <= int'(len); i++) begin
      ok = in_range(addr, i) && (size == 3'd6);
      exp_d.push_back(ok ? model[word_of(addr, i)] : '0);
      exp_r.push_back(ok ? 2'b00 : 2'b10);
    end
    arid = id; araddr = addr; arlen = len; arsize = size; arvalid = 1'b1;
    @(negedge clk);
    check("ar_ready", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    b = 0; cyc = 0;
    while (b <= int'(len) && cyc < 200) begin
      rready = bp ? pat[cyc % 4] : 1'b1;
      @(negedge clk);
      check("r_valid", rvalid, 1);
      check("r_id", rid, id);
      check("r_data", rdata, exp_d[b]);
      check("r_resp", rresp, exp_r[b]);
      check("r_last", rlast, (b == int'(len)));
      if (rvalid && rready) b++;
      @(posedge clk); #1;
      cyc++;
    end
    check("r_beat_count", 512'(b), 512'(int'(len) + 1));
    rready = 1'b0;
    @(negedge clk);
    check("r_drop", rvalid, 0);
    check("ar_reopen", arready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [63:0] a;
    logic [7:0]  l;
    logic [511:0] d;
    nreset = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd6; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd6; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", awready, 1);
    check("rst_arready", arready, 1);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rresp", rresp, 0);
    check("rst_bid", bid, 0);
    check("rst_rid", rid, 0);
    check("rst_rdata", rdata, 0);
    nreset = 1'b1;
    @(posedge clk); #1;

    // single beat
    do_write(16'd5, 64'h40, 8'd0, 3'd6, 1, '1, -1, 0);
    do_read(16'd7, 64'h40, 8'd0, 3'd6, 1'b0);

    // 4-beat burst, then partial strobe on beat 2
    do_write(16'd1, 64'h1000, 8'd3, 3'd6, 4, '1, -1, 0);
    do_write(16'd2, 64'h1000, 8'd3, 3'd6, 4, 64'hFF, 2, 0);
    do_read(16'd3, 64'h1000, 8'd3, 3'd6, 1'b0);

    // backpressure on B and R
    do_write(16'd4, 64'h2000, 8'd3, 3'd6, 4, '1, -1, 5);
    do_read(16'd9, 64'h2000, 8'd3, 3'd6, 1'b1);

    // end of memory
    do_write(16'hA, 64'(1023 * 64), 8'd1, 3'd6, 2, '1, -1, 0);
    do_read(16'hB, 64'(1023 * 64), 8'd1, 3'd6, 1'b0);

    // protocol errors
    do_write(16'hC, 64'h3000, 8'd3, 3'd6, 4, '1, -1, 0);
    do_write(16'hD, 64'h3000, 8'd3, 3'd6, 2, '1, -1, 0);
    do_write(16'hE, 64'h3000, 8'd1, 3'd5, 2, '1, -1, 0);
    do_read(16'hF, 64'h3000, 8'd3, 3'd6, 1'b0);
    do_read(16'h10, 64'h3000, 8'd2, 3'd5, 1'b0);

    // randomized bursts, unaligned low address bits
    for (int it = 0; it < 6; it++) begin
      l = 8'($urandom_range(0, 7));
      a = 64'($urandom_range(0, 1000)) * 64 + 64'($urandom_range(0, 63));
      do_write(16'($urandom), a, l, 3'd6, int'(l) + 1, '1, -1, $urandom_range(0, 2));
      do_write(16'($urandom), a, l, 3'd6, int'(l) + 1, {$urandom, $urandom},
               $urandom_range(0, int'(l)), 0);
      do_read(16'($urandom), a, l, 3'd6, 1'($urandom_range(0, 1)));
    end

    // reset in the middle of a write and a read burst
    awid = 16'h40; awaddr = 64'h5000; awlen = 8'd3; awsize = 3'd6; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      d = rnd512();
      wdata = d; wstrb = '1; wlast = 1'b0; wvalid = 1'b1;
      @(posedge clk); #1;
      model_write(64'h5000, b, d, '1);
    end
    wvalid = 1'b0;
    arid = 16'h41; araddr = 64'h1000; arlen = 8'd3; arsize = 3'd6; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    #1 nreset = 1'b0;
    #1;
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_rlast", rlast, 0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_wready", wready, 0);
    check("mid_rst_bvalid", bvalid, 0);
    check("mid_rst_awready", awready, 1);
    check("mid_rst_arready", arready, 1);
    rready = 1'b0;
    @(posedge clk); #1;
    nreset = 1'b1;
    @(posedge clk); #1;
    do_read(16'h42, 64'h5000, 8'd1, 3'd6, 1'b0);
    do_read(16'h43, 64'h1000, 8'd3, 3'd6, 1'b0);
    do_write(16'h44, 64'h5000, 8'd3, 3'd6, 4, '1, -1, 0);
    do_read(16'h45, 64'h5000, 8'd3, 3'd6, 1'b0);

    // concurrent write and read of the same word: read sees pre-write data
    do_write(16'h50, 64'h6000, 8'd0, 3'd6, 1, '1, -1, 0);
    fork
      do_write(16'h51, 64'h6000, 8'd0, 3'd6, 1, '1, -1, 0);
      begin
        @(posedge clk); #1;
        do_read(16'h52, 64'h6000, 8'd0, 3'd6, 1'b0);
      end
    join
    do_read(16'h53, 64'h6000, 8'd0, 3'd6, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
